seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 8-bit unsigned datapath.
- Adds run-time signed/unsigned mode, a full 2*WIDTH product, start/ready/done handshake, and early termination once the remaining multiplier bits are zero.
- Sits beside the ALU as a multi-cycle execution unit. Operands are captured on start; the result is held until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- multiplicand  input  WIDTH  operand A, sampled with start
- multiplier  input  WIDTH  operand B, sampled with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and SIGN
- done  output  1  one-cycle pulse; product valid from this cycle on
- product  output  2*WIDTH  registered result, held until the next completion
- zflag  output  1  registered; 1 if the captured multiplier was zero, updated at accept

Behaviour:
- Reset: async to IDLE. ready=1, busy=0, done=0, product=0, zflag=0, internal registers 0.
- FSM states: IDLE, RUN, SIGN, DONE.
- IDLE, on start=1:
  - If signed_mode=1, latch magnitudes |A| and |B| as WIDTH-bit unsigned, and neg = A[MSB]^B[MSB]. The most negative value maps to 2^(WIDTH-1), which is representable.
  - If signed_mode=0, latch A and B unchanged, neg=0.
  - Clear the 2*WIDTH accumulator, counter=0, set zflag=(B==0).
  - Next state is RUN if the magnitude of B != 0, otherwise SIGN.
- RUN, per cycle:
  - If mplr[0]=1, acc += mcand (mcand is 2*WIDTH, zero-extended).
  - Then mcand <<= 1, mplr >>= 1, counter++.
  - Go to SIGN when the shifted mplr == 0 or counter reaches WIDTH-1. The counter is a safety bound only.
- SIGN (1 cycle): product <= neg ? -acc : acc, truncated to 2*WIDTH bits (two's complement). No overflow is possible.
- DONE (1 cycle): done=1, then IDLE. ready is low in DONE, so a new start is accepted no earlier than the cycle after done.
- Latency: let k = index of the highest set bit of |B| + 1 (k=0 for B=0). done is high in the cycle following k+2 rising edges after the accept edge. Worst case is WIDTH+2, best case 2.
- Start while not ready is ignored: no state change, operands not re-sampled. Operand/mode changes after accept have no effect.
- product and zflag change only at SIGN exit and accept respectively; otherwise they are stable.
- Reset asserted mid-operation: immediate abort to reset values. No done pulse; the partial result is discarded.
- signed_mode=0 with MSB set: treated as a large unsigned value, no sign handling.

Test Plan:
- WIDTH=8, unsigned 13*11 -> product=143 (0x008F); B=0b1011 gives k=4, so done exactly 6 edges after accept; busy high for 5 cycles, ready low for 6.
- WIDTH=8, signed -5*3 -> 0xFFF1; signed -128*-128 -> 0x4000; signed -128*127 -> 0xC080; unsigned 255*255 -> 0xFE01, with k=8 giving done at 10 edges.
- Multiplier=0 (A=0x7F) -> product=0, zflag=1, done 2 edges after accept; then 1*1 -> zflag=0, product=1.
- Start pulsed every cycle during an operation with changing operands -> only the first operation is performed; the result is unchanged, ready/done sequence is as specified, and the next accept occurs only after done.
- rst_n dropped asynchronously mid-RUN (between edges) -> outputs immediately take reset values and no done appears. After release, 7*9 completes with product=63.
- WIDTH=16: unsigned 0xFFFF*0xFFFF -> 0xFFFE0001 with done at 18 edges; signed 0x8000*0x0001 -> 0xFFFF8000.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned mode, start/ready/done
// handshake and early exit once the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 zflag
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mplr_shr;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    if (signed_mode && multiplicand[WIDTH-1]) mag_a = -multiplicand;
    if (signed_mode && multiplier[WIDTH-1])   mag_b = -multiplier;
    mplr_shr = mplr >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      zflag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= PW'(mag_a);
            mplr  <= mag_b;
            neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            zflag <= (multiplier == '0);
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= (mag_b != '0) ? RUN : SIGN;
          end
        end
        RUN: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr_shr;
          cnt   <= cnt + CNT_W'(1);
          // Counter is only a safety bound; the zero check normally ends the run.
          if (mplr_shr == '0 || cnt == CNT_W'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          product <= neg ? -acc : acc;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed scoreboard bench for seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sm8, ready8, busy8, done8, z8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start16, sm16, ready16, busy16, done16, z16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .ready(ready8), .busy(busy8),
    .done(done8), .product(p8), .zflag(z8)
  );

  seq_multiplier #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .ready(ready16), .busy(busy16),
    .done(done16), .product(p16), .zflag(z16)
  );

  typedef struct {
    logic [31:0] prod;
    logic        z;
    int          edges;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: product masked to 2w bits and done latency k+2 edges.
  function automatic exp_t model(input int w, input bit sm, input longint a, input longint b);
    exp_t   e;
    longint sa, sb, mb, p, full;
    int     k;
    full = (longint'(1) << w);
    sa = (sm && a[w-1]) ? a - full : a;
    sb = (sm && b[w-1]) ? b - full : b;
    mb = (sm && b[w-1]) ? full - b : b;
    p  = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    k  = 0;
    for (int i = 0; i < w; i++) if (mb[i]) k = i + 1;
    e.prod  = 32'(p);
    e.z     = (b == 0);
    e.edges = k + 2;
    return e;
  endfunction

  task automatic run8(input string tag, input bit sm, input logic [7:0] a, input logic [7:0] b,
                      input bit spam);
    exp_t e;
    int   edges, busy_c, rlow;
    q.push_back(model(8, sm, longint'(a), longint'(b)));
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    edges = 1;
    if (!spam) start8 = 1'b0;
    busy_c = busy8 ? 1 : 0;
    rlow   = ready8 ? 0 : 1;
    while (!done8 && edges < 40) begin
      if (spam) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
      if (busy8) busy_c++;
      if (!ready8) rlow++;
    end
    start8 = 1'b0;
    e = q.pop_front();
    chk({tag, "_latency"}, 32'(edges), 32'(e.edges));
    chk({tag, "_product"}, {16'h0, p8}, e.prod);
    chk({tag, "_zflag"}, {31'h0, z8}, {31'h0, e.z});
    chk({tag, "_busy_cycles"}, 32'(busy_c), 32'(e.edges - 1));
    chk({tag, "_ready_low"}, 32'(rlow), 32'(e.edges));
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {31'h0, ready8}, 32'h1);
    chk({tag, "_held"}, {16'h0, p8}, e.prod);
  endtask

  task automatic run16(input string tag, input bit sm, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   edges;
    q.push_back(model(16, sm, longint'(a), longint'(b)));
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(posedge clk); #1;
    edges = 1;
    start16 = 1'b0;
    while (!done16 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    e = q.pop_front();
    chk({tag, "_latency"}, 32'(edges), 32'(e.edges));
    chk({tag, "_product"}, p16, e.prod);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    chk("rst_ready", {31'h0, ready8}, 32'h1);
    chk("rst_busy", {31'h0, busy8}, 32'h0);
    chk("rst_done", {31'h0, done8}, 32'h0);
    chk("rst_product", {16'h0, p8}, 32'h0);
    chk("rst_zflag", {31'h0, z8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8("u13x11", 1'b0, 8'd13, 8'd11, 1'b0);
    chk("u13x11_const", {16'h0, p8}, 32'h008F);
    run8("s-5x3", 1'b1, 8'hFB, 8'h03, 1'b0);
    chk("s-5x3_const", {16'h0, p8}, 32'hFFF1);
    run8("s-128x-128", 1'b1, 8'h80, 8'h80, 1'b0);
    run8("s-128x127", 1'b1, 8'h80, 8'h7F, 1'b0);
    run8("u255x255", 1'b0, 8'hFF, 8'hFF, 1'b0);
    run8("zero_b", 1'b0, 8'h7F, 8'h00, 1'b0);
    run8("one_x_one", 1'b0, 8'h01, 8'h01, 1'b0);
    run8("s_neg_zero", 1'b1, 8'hFB, 8'h00, 1'b0);
    run8("spam", 1'b0, 8'd200, 8'd37, 1'b1);
    run8("after_spam", 1'b1, 8'h7F, 8'h81, 1'b0);

    // Abort mid-run with an asynchronous reset between clock edges.
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'h0, ready8}, 32'h1);
    chk("abort_busy", {31'h0, busy8}, 32'h0);
    chk("abort_product", {16'h0, p8}, 32'h0);
    chk("abort_zflag", {31'h0, z8}, 32'h0);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done8) seen_done++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'h0);
    run8("u7x9", 1'b0, 8'd7, 8'd9, 1'b0);
    chk("u7x9_const", {16'h0, p8}, 32'd63);

    run16("w16_uffff", 1'b0, 16'hFFFF, 16'hFFFF);
    chk("w16_uffff_const", p16, 32'hFFFE0001);
    run16("w16_s8000x1", 1'b1, 16'h8000, 16'h0001);
    chk("w16_s8000x1_const", p16, 32'hFFFF8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
